// File: rtl/baby_cycle_sequencer.sv
// Four-beat machine-cycle sequencer for the Manchester Baby, with run/step/stop and display arbitration.
// Optional completed-instruction counter enabled by defining BABY_INSTR_COUNT_EN.
module baby_cycle_sequencer #(
  parameter int BEAT_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       RUN,
  input  logic       STEP,
  input  logic       STOP_REQ,
  input  logic       DISP_REQ,
  output logic       DISP_GNT,
  output logic [1:0] BEAT,
  output logic       CI_INC,
  output logic       FETCH,
  output logic       OPERAND,
  output logic       EXEC,
  output logic       HALTED
`ifdef BABY_INSTR_COUNT_EN
  ,
  output logic [15:0] INSTR_COUNT
`endif
);

  localparam int CW = $clog2(BEAT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HALT,
    S_SCAN1,
    S_ACTION1,
    S_SCAN2,
    S_ACTION2
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            step_flag, step_nx;
  logic            stop_latch, stop_nx;
  logic            run_q;
  logic            last;
  logic            run_rise;

  function automatic logic [1:0] beat_of(state_t s);
    case (s)
      S_ACTION1: beat_of = 2'd1;
      S_SCAN2:   beat_of = 2'd2;
      S_ACTION2: beat_of = 2'd3;
      default:   beat_of = 2'd0;
    endcase
  endfunction

  assign last     = (cnt == LAST);
  assign run_rise = RUN && !run_q;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    step_nx  = step_flag;
    stop_nx  = stop_latch;
    cnt_nx   = (state == S_HALT || last) ? '0 : cnt + CW'(1);
    case (state)
      S_HALT: begin
        if (run_rise) begin
          state_nx = S_SCAN1;
          step_nx  = 1'b0;
        end else if (!RUN && STEP) begin
          state_nx = S_SCAN1;
          step_nx  = 1'b1;
        end
      end
      S_SCAN1:   if (last) state_nx = S_ACTION1;
      S_ACTION1: if (last) state_nx = S_SCAN2;
      S_SCAN2:   if (last) state_nx = S_ACTION2;
      S_ACTION2: begin
        if (STOP_REQ) stop_nx = 1'b1;
        if (last) begin
          // A stop request on the final cycle still counts, even though the latch clears here.
          state_nx = (stop_latch || STOP_REQ || !RUN || step_flag) ? S_HALT : S_SCAN1;
          stop_nx  = 1'b0;
          step_nx  = 1'b0;
        end
      end
      default: begin
        state_nx = S_HALT;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state and count.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= S_HALT;
      cnt        <= '0;
      step_flag  <= 1'b0;
      stop_latch <= 1'b0;
      run_q      <= 1'b0;
      HALTED     <= 1'b1;
      BEAT       <= 2'd0;
      CI_INC     <= 1'b0;
      FETCH      <= 1'b0;
      OPERAND    <= 1'b0;
      EXEC       <= 1'b0;
      DISP_GNT   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      step_flag  <= step_nx;
      stop_latch <= stop_nx;
      run_q      <= RUN;
      HALTED     <= (state_nx == S_HALT);
      BEAT       <= beat_of(state_nx);
      CI_INC     <= (state_nx == S_SCAN1)   && (cnt_nx == LAST);
      FETCH      <= (state_nx == S_ACTION1) && (cnt_nx == LAST);
      OPERAND    <= (state_nx == S_SCAN2)   && (cnt_nx == LAST);
      EXEC       <= (state_nx == S_ACTION2) && (cnt_nx == LAST);
      DISP_GNT   <= DISP_REQ && ((state == S_HALT) ||
                    (((state == S_SCAN1) || (state == S_SCAN2)) && !last));
    end
  end

`ifdef BABY_INSTR_COUNT_EN
  always_ff @(posedge CLK) begin
    if (!RESET_N)  INSTR_COUNT <= 16'h0000;
    else if (EXEC) INSTR_COUNT <= INSTR_COUNT + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_baby_cycle_sequencer.sv
// Directed bench for baby_cycle_sequencer with BEAT_CYCLES=4 (16-clock machine cycle).
module tb_baby_cycle_sequencer;

  logic       CLK = 1'b0;
  logic       RESET_N, RUN, STEP, STOP_REQ, DISP_REQ;
  logic       DISP_GNT, CI_INC, FETCH, OPERAND, EXEC, HALTED;
  logic [1:0] BEAT;
`ifdef BABY_INSTR_COUNT_EN
  logic [15:0] INSTR_COUNT;
`endif

  int checks = 0;
  int errors = 0;

  baby_cycle_sequencer #(.BEAT_CYCLES(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .RUN(RUN), .STEP(STEP), .STOP_REQ(STOP_REQ),
    .DISP_REQ(DISP_REQ), .DISP_GNT(DISP_GNT), .BEAT(BEAT), .CI_INC(CI_INC),
    .FETCH(FETCH), .OPERAND(OPERAND), .EXEC(EXEC), .HALTED(HALTED)
`ifdef BABY_INSTR_COUNT_EN
    , .INSTR_COUNT(INSTR_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Advance one edge and settle; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Strobes {CI_INC,FETCH,OPERAND,EXEC} expected at clock k (k>=1) after a start.
  function automatic logic [3:0] exp_strb(int k);
    case (k % 16)
      4:       exp_strb = 4'b1000;
      8:       exp_strb = 4'b0100;
      12:      exp_strb = 4'b0010;
      0:       exp_strb = 4'b0001;
      default: exp_strb = 4'b0000;
    endcase
  endfunction

  function automatic logic [1:0] exp_beat(int k);
    exp_beat = 2'(((k - 1) / 4) % 4);
  endfunction

  task automatic wait_halt(input string name);
    for (int i = 0; i < 40 && !HALTED; i++) tick();
    checks++;
    if (HALTED !== 1'b1) begin
      errors++;
      $display("FAIL %s halt timeout: HALTED=%b required 1", name, HALTED);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; RUN = 1'b0; STEP = 1'b0; STOP_REQ = 1'b0; DISP_REQ = 1'b1;
    tick(); tick();
    checks++;
    if ({HALTED, BEAT, CI_INC, FETCH, OPERAND, EXEC, DISP_GNT} !== 8'b1_00_0000_0) begin
      errors++;
      $display("FAIL reset: got H=%b B=%0d strb=%b%b%b%b G=%b required H=1 B=0 strb=0000 G=0",
               HALTED, BEAT, CI_INC, FETCH, OPERAND, EXEC, DISP_GNT);
    end
    DISP_REQ = 1'b0;
    RESET_N  = 1'b1;
    tick(); tick();
  endtask

  // Start with RUN rise and STEP together (run wins), then a STEP mid-run is ignored.
  task automatic test_run();
    RUN = 1'b1; STEP = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      STEP = (k == 1 || k == 20);
      tick();
      STEP = 1'b0;
      checks++;
      if (HALTED !== 1'b0 || BEAT !== exp_beat(k)) begin
        errors++;
        $display("FAIL run beat k=%0d: got H=%b B=%0d required H=0 B=%0d", k, HALTED, BEAT, exp_beat(k));
      end
      checks++;
      if ({CI_INC, FETCH, OPERAND, EXEC} !== exp_strb(k)) begin
        errors++;
        $display("FAIL run strobe k=%0d: got %b required %b", k, {CI_INC, FETCH, OPERAND, EXEC}, exp_strb(k));
      end
    end
    RUN = 1'b0;
    wait_halt("run");
  endtask

  task automatic test_step();
    for (int k = 1; k <= 22; k++) begin
      STEP = (k == 1 || k == 6);
      tick();
      STEP = 1'b0;
      checks++;
      if (HALTED !== (k >= 17)) begin
        errors++;
        $display("FAIL step halted k=%0d: got %b required %b", k, HALTED, (k >= 17));
      end
      checks++;
      if ({CI_INC, FETCH, OPERAND, EXEC} !== ((k <= 16) ? exp_strb(k) : 4'b0000)) begin
        errors++;
        $display("FAIL step strobe k=%0d: got %b required %b", k, {CI_INC, FETCH, OPERAND, EXEC},
                 (k <= 16) ? exp_strb(k) : 4'b0000);
      end
    end
  endtask

  task automatic test_stop();
    RUN = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      STOP_REQ = (k == 14);
      tick();
      STOP_REQ = 1'b0;
      checks++;
      if ({CI_INC, FETCH, OPERAND, EXEC} !== ((k <= 16) ? exp_strb(k) : 4'b0000)) begin
        errors++;
        $display("FAIL stop strobe k=%0d: got %b", k, {CI_INC, FETCH, OPERAND, EXEC});
      end
    end
    checks++;
    if (HALTED !== 1'b1) begin
      errors++;
      $display("FAIL stop halt: HALTED=%b required 1", HALTED);
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (HALTED !== 1'b1) begin
      errors++;
      $display("FAIL stop hold with RUN=1: HALTED=%b required 1", HALTED);
    end
    RUN = 1'b0; tick();
    RUN = 1'b1; tick();
    checks++;
    if (HALTED !== 1'b0) begin
      errors++;
      $display("FAIL stop restart: HALTED=%b required 0", HALTED);
    end
    tick(); tick(); tick();
    checks++;
    if (CI_INC !== 1'b1) begin
      errors++;
      $display("FAIL restart ci_inc: got %b required 1", CI_INC);
    end
    RUN = 1'b0;
    wait_halt("stop");
  endtask

  task automatic test_disp();
    logic want;
    tick();
    checks++;
    if (DISP_GNT !== 1'b0) begin
      errors++;
      $display("FAIL disp idle: got %b required 0", DISP_GNT);
    end
    DISP_REQ = 1'b1;
    tick();
    checks++;
    if (DISP_GNT !== 1'b1) begin
      errors++;
      $display("FAIL disp halted grant: got %b required 1", DISP_GNT);
    end
    RUN = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      // Grant reflects the position one clock earlier: SCAN beats except their last cycle.
      if (k == 1) want = 1'b1;
      else want = (exp_beat(k - 1) == 2'd0 || exp_beat(k - 1) == 2'd2) && (((k - 2) % 4) != 3);
      checks++;
      if (DISP_GNT !== want) begin
        errors++;
        $display("FAIL disp run k=%0d beat=%0d: got %b required %b", k, BEAT, DISP_GNT, want);
      end
    end
    RUN = 1'b0;
    wait_halt("disp");
    checks++;
    if (DISP_GNT !== 1'b0) begin
      errors++;
      $display("FAIL disp first halted cycle: got %b required 0", DISP_GNT);
    end
    tick();
    checks++;
    if (DISP_GNT !== 1'b1) begin
      errors++;
      $display("FAIL disp regrant: got %b required 1", DISP_GNT);
    end
    DISP_REQ = 1'b0;
    tick();
    checks++;
    if (DISP_GNT !== 1'b0) begin
      errors++;
      $display("FAIL disp release: got %b required 0", DISP_GNT);
    end
  endtask

  task automatic test_run_drop();
    RUN = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      RUN = (k <= 6);
      tick();
      checks++;
      if ({CI_INC, FETCH, OPERAND, EXEC} !== ((k <= 16) ? exp_strb(k) : 4'b0000)) begin
        errors++;
        $display("FAIL drop strobe k=%0d: got %b required %b", k, {CI_INC, FETCH, OPERAND, EXEC},
                 (k <= 16) ? exp_strb(k) : 4'b0000);
      end
    end
    checks++;
    if (HALTED !== 1'b1) begin
      errors++;
      $display("FAIL drop halt: HALTED=%b required 1", HALTED);
    end
  endtask

  task automatic test_reset_mid();
    RUN = 1'b1;
    for (int k = 1; k <= 10; k++) tick();
    checks++;
    if (BEAT !== 2'd2) begin
      errors++;
      $display("FAIL midreset pre beat: got %0d required 2", BEAT);
    end
    RESET_N = 1'b0;
    for (int k = 11; k <= 18; k++) begin
      tick();
      checks++;
      if ({HALTED, BEAT, EXEC, OPERAND} !== 5'b1_00_0_0) begin
        errors++;
        $display("FAIL midreset k=%0d: got H=%b B=%0d EXEC=%b OPERAND=%b required H=1 B=0 0 0",
                 k, HALTED, BEAT, EXEC, OPERAND);
      end
    end
    RUN = 1'b0;
    RESET_N = 1'b1;
    tick(); tick();
    checks++;
    if (HALTED !== 1'b1 || EXEC !== 1'b0) begin
      errors++;
      $display("FAIL midreset release: got H=%b EXEC=%b required H=1 EXEC=0", HALTED, EXEC);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
    test_stop();
    test_disp();
    test_run_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
